// File: rtl/tl_pkg.sv
// Shared traffic-light types and timing constants, common to the pass
// request conditioner and the traffic-light FSM it feeds.
package tl_pkg;

  localparam int TL_G1_CYC       = 1024;
  localparam int TL_DEBOUNCE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } pcond_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; two cycles of latency,
// both flops clear on synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pass_request_conditioner.sv
// Pedestrian button conditioner: synchronise, debounce both edges, one-cycle pass
// per confirmed press (DEBOUNCE_CYC+2 edges after a stable press), lockout window.
module pass_request_conditioner
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = TL_DEBOUNCE_DEF,
  parameter int LOCKOUT_CYC  = TL_G1_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pass,
  output logic btn_level,
  output logic lockout
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LKW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYC);
  localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
  localparam logic [LKW-1:0] LOCK_MAX = LKW'(LOCKOUT_CYC);
  localparam logic [LKW-1:0] LOCK_ONE = LKW'(1);

  logic btn_s;

  pcond_state_t   state, state_nxt;
  logic [DBW-1:0] db_cnt, db_nxt;
  logic [LKW-1:0] lock_cnt, lock_nxt;
  logic           pass_nxt;
  logic           level_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      lock_cnt  <= '0;
      pass      <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_nxt;
      lock_cnt  <= lock_nxt;
      pass      <= pass_nxt;
      btn_level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    db_nxt    = db_cnt;
    pass_nxt  = 1'b0;
    level_nxt = btn_level;
    lock_nxt  = (lock_cnt != '0) ? (lock_cnt - LOCK_ONE) : '0;

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_DB;
          db_nxt    = DB_ONE;
        end
      end

      PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          db_nxt    = '0;
        end else if (db_cnt == DB_MAX) begin
          state_nxt = HELD;
          level_nxt = 1'b1;
          db_nxt    = '0;
          // Presses confirmed while still locked out are dropped, not queued.
          if (lock_cnt == '0) begin
            pass_nxt = 1'b1;
            lock_nxt = LOCK_MAX;
          end
        end else begin
          db_nxt = db_cnt + DB_ONE;
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_DB;
          db_nxt    = DB_ONE;
        end
      end

      REL_DB: begin
        if (btn_s) begin
          state_nxt = HELD;
          db_nxt    = '0;
        end else if (db_cnt == DB_MAX) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
          db_nxt    = '0;
        end else begin
          db_nxt = db_cnt + DB_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        db_nxt    = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  assign lockout = (lock_cnt != '0);

endmodule

// File: tb/tb_pass_request_conditioner.sv
// Directed and randomised bench for pass_request_conditioner against a
// run-length / time-stamp reference model.
module tb_pass_request_conditioner;
  import tl_pkg::*;

  localparam int D  = TL_DEBOUNCE_DEF;
  localparam int LK = TL_G1_CYC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_raw = 1'b0;
  logic pass, btn_level, lockout;

  pass_request_conditioner #(
    .DEBOUNCE_CYC (D),
    .LOCKOUT_CYC  (LK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .pass      (pass),
    .btn_level (btn_level),
    .lockout   (lockout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  // Reference model: two-stage delay line, then a level that flips once the
  // synchronised input has disagreed with it for D+1 consecutive edges.
  logic m_s1 = 1'b0, m_bs = 1'b0, m_level = 1'b0, m_pass = 1'b0;
  int   m_run = 0;
  bit   m_have = 1'b0;
  int   m_last = 0;

  int pass_cnt = 0, last_pass = 0, lvl_ticks = 0, lock_ticks = 0;
  int base, p1, p3, p4, p5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s t=%0d: observed %0d required %0d", tag, t, obs, want);
    end
  endtask

  task automatic tick(input logic b, input logic r);
    logic want_lock;
    btn_raw = b;
    rst     = r;
    @(posedge clk);
    t++;
    if (!r) begin
      m_s1 = 1'b0; m_bs = 1'b0; m_level = 1'b0; m_pass = 1'b0;
      m_run = 0; m_have = 1'b0;
    end else begin
      m_pass = 1'b0;
      if (m_bs != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = ~m_level;
          m_run   = 0;
          if (m_level && !(m_have && t <= m_last + LK)) begin
            m_pass = 1'b1;
            m_have = 1'b1;
            m_last = t;
          end
        end
      end else begin
        m_run = 0;
      end
      m_bs = m_s1;
      m_s1 = b;
    end
    want_lock = (m_have && (t - m_last) < LK);
    #1;
    check("pass", {31'b0, pass}, {31'b0, m_pass});
    check("btn_level", {31'b0, btn_level}, {31'b0, m_level});
    check("lockout", {31'b0, lockout}, {31'b0, want_lock});
    if (pass === 1'b1) begin
      pass_cnt++;
      last_pass = t;
    end
    if (btn_level === 1'b1) lvl_ticks++;
    if (lockout === 1'b1) lock_ticks++;
  endtask

  initial begin
    // Reset held with the button pressed.
    repeat (3) tick(1'b1, 1'b0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    check("rst_level", {31'b0, btn_level}, 32'd0);
    check("rst_lockout", {31'b0, lockout}, 32'd0);

    // First press straight out of reset: pass at released edge index 18.
    pass_cnt = 0;
    base = t;
    repeat (25) tick(1'b1, 1'b1);
    check("first_pass_cnt", pass_cnt, 32'd1);
    check("first_pass_edge", last_pass - base - 1, 32'd18);
    check("first_level", {31'b0, btn_level}, 32'd1);
    check("first_lockout", {31'b0, lockout}, 32'd1);
    repeat (1100) tick(1'b0, 1'b1);

    // Bounce: short highs never confirm.
    pass_cnt = 0; lvl_ticks = 0;
    repeat (4) begin
      repeat (10) tick(1'b1, 1'b1);
      repeat (2) tick(1'b0, 1'b1);
    end
    repeat (20) tick(1'b0, 1'b1);
    check("bounce_pass", pass_cnt, 32'd0);
    check("bounce_level", lvl_ticks, 32'd0);

    // Clean press, then a press confirmed 500 cycles into lockout.
    pass_cnt = 0; lvl_ticks = 0; lock_ticks = 0;
    repeat (40) tick(1'b1, 1'b1);
    p1 = last_pass;
    check("clean_pass_cnt", pass_cnt, 32'd1);
    repeat (40) tick(1'b0, 1'b1);
    check("clean_level_ticks", lvl_ticks, 32'd40);
    while (t < p1 + 481) tick(1'b0, 1'b1);
    pass_cnt = 0; lvl_ticks = 0;
    repeat (40) tick(1'b1, 1'b1);
    repeat (40) tick(1'b0, 1'b1);
    check("locked_pass_cnt", pass_cnt, 32'd0);
    check("locked_level_ticks", lvl_ticks, 32'd40);
    while (t < p1 + 1081) tick(1'b0, 1'b1);
    check("lockout_len", lock_ticks, 32'd1024);

    // Press confirmed 1100 cycles after the first pass.
    pass_cnt = 0;
    repeat (40) tick(1'b1, 1'b1);
    check("third_pass_cnt", pass_cnt, 32'd1);
    check("third_pass_gap", last_pass - p1, 32'd1100);
    p3 = last_pass;
    repeat (40) tick(1'b0, 1'b1);

    // Confirmation on the edge where lock_cnt==1 is still suppressed.
    while (t < p3 + 1005) tick(1'b0, 1'b1);
    pass_cnt = 0;
    repeat (40) tick(1'b1, 1'b1);
    check("bound_lock1", pass_cnt, 32'd0);
    repeat (40) tick(1'b0, 1'b1);
    pass_cnt = 0;
    repeat (40) tick(1'b1, 1'b1);
    check("bound_rearm", pass_cnt, 32'd1);
    p4 = last_pass;
    repeat (40) tick(1'b0, 1'b1);

    // One edge later (lock_cnt==0) the press is accepted.
    while (t < p4 + 1006) tick(1'b0, 1'b1);
    pass_cnt = 0;
    repeat (40) tick(1'b1, 1'b1);
    check("bound_lock0", pass_cnt, 32'd1);
    check("bound_lock0_gap", last_pass - p4, 32'd1025);
    p5 = last_pass;
    repeat (40) tick(1'b0, 1'b1);

    // Reset with 300 cycles of lockout left clears it.
    while (t < p5 + 724) tick(1'b0, 1'b1);
    check("pre_rst_lockout", {31'b0, lockout}, 32'd1);
    tick(1'b0, 1'b0);
    check("mid_rst_lockout", {31'b0, lockout}, 32'd0);
    pass_cnt = 0;
    repeat (40) tick(1'b1, 1'b1);
    check("post_rst_pass", pass_cnt, 32'd1);
    repeat (40) tick(1'b0, 1'b1);

    // Random bouncing with occasional resets.
    for (int k = 0; k < 250; k++) begin
      logic lvl;
      logic r;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      r   = ($urandom_range(0, 99) != 0);
      for (int j = 0; j < len; j++) tick(lvl, (j == 0) ? r : 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
